mgmt_bus_arbiter: RTL and testbench

Shares the single byte-wide management register bus between several bus masters, such as the QSPI bridge, the simulation bridge and a future in-band Ethernet management path. It sits between those masters and the management register block. It serialises their reads and writes with round-robin fairness, and it holds the read address stable until the register block returns data. A timeout keeps a read of a never-valid register from locking up the bus.

---
 rtl/mgmt_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mgmt_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_bus_arbiter.sv
// Round-robin arbiter sharing the byte-wide management register bus among
// NUM_REQ masters; one command slot per master, read timeout in RD_WAIT.

package mgmt_bus_pkg;
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        wr;
   } mgmt_cmd_t;
endpackage

// One command slot: accepts a strobe only when empty, flags drops.
module mgmt_bus_slot (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [15:0]            addr,
   input  logic [7:0]             wr_data,
   input  logic                   clr,
   output logic                   busy,
   output logic                   overflow,
   output mgmt_bus_pkg::mgmt_cmd_t cmd
);
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         overflow <= 1'b0;
         cmd      <= '0;
      end else begin
         // rd+wr together always loses the read, even into an empty slot
         overflow <= (rd_en | wr_en) & (busy | (rd_en & wr_en));
         if (clr)
            busy <= 1'b0;
         else if (!busy && (rd_en | wr_en)) begin
            busy     <= 1'b1;
            cmd.addr <= addr;
            cmd.data <= wr_data;
            cmd.wr   <= wr_en;
         end
      end
   end
endmodule

module mgmt_bus_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_rd_en,
   input  logic [NUM_REQ-1:0]     req_wr_en,
   input  logic [16*NUM_REQ-1:0]  req_addr,
   input  logic [8*NUM_REQ-1:0]   req_wr_data,
   output logic [NUM_REQ-1:0]     req_busy,
   output logic [NUM_REQ-1:0]     req_rd_valid,
   output logic [7:0]             req_rd_data,
   output logic [NUM_REQ-1:0]     req_rd_timeout,
   output logic [NUM_REQ-1:0]     req_overflow,
   output logic                   mgmt_rd_en,
   output logic [15:0]            mgmt_rd_addr,
   input  logic                   mgmt_rd_valid,
   input  logic [7:0]             mgmt_rd_data,
   output logic                   mgmt_wr_en,
   output logic [15:0]            mgmt_wr_addr,
   output logic [7:0]             mgmt_wr_data
);
   import mgmt_bus_pkg::*;

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

   state_t                    state_q, state_d;
   mgmt_cmd_t [NUM_REQ-1:0]   slot_cmd;
   logic [NUM_REQ-1:0]        slot_clr;
   logic [PW-1:0]             ptr_q, grant_q, pick;
   logic                      found;
   logic [CW-1:0]             cnt_q;
   logic [15:0]               rd_addr_q, wr_addr_q;
   logic [7:0]                wr_data_q;
   logic                      rd_ok, rd_to, done;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      mgmt_bus_slot u_slot (
         .clk      (clk),
         .rst      (rst),
         .rd_en    (req_rd_en[g]),
         .wr_en    (req_wr_en[g]),
         .addr     (req_addr[16*g +: 16]),
         .wr_data  (req_wr_data[8*g +: 8]),
         .clr      (slot_clr[g]),
         .busy     (req_busy[g]),
         .overflow (req_overflow[g]),
         .cmd      (slot_cmd[g])
      );
      assign slot_clr[g] = done && (grant_q == PW'(g));
   end

   // First pending slot at or after ptr; scanning i downward leaves the nearest.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = NUM_REQ-1; i >= 0; i--)
         for (int p = 0; p < NUM_REQ; p++)
            if (ptr_q == PW'(p) && req_busy[(p+i) % NUM_REQ]) begin
               found = 1'b1;
               pick  = PW'((p+i) % NUM_REQ);
            end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mgmt_wr_en = 1'b0;
      mgmt_rd_en = 1'b0;
      rd_ok      = 1'b0;
      rd_to      = 1'b0;
      case (state_q)
         IDLE:     if (found) state_d = slot_cmd[pick].wr ? WR : RD_ISSUE;
         WR: begin
            mgmt_wr_en = 1'b1;
            state_d    = IDLE;
         end
         RD_ISSUE: begin
            mgmt_rd_en = 1'b1;
            state_d    = RD_WAIT;
         end
         RD_WAIT: begin
            // valid wins over a coincident timeout
            if (mgmt_rd_valid) begin
               rd_ok   = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               rd_to   = 1'b1;
               state_d = IDLE;
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   assign done         = mgmt_wr_en | rd_ok | rd_to;
   assign mgmt_rd_addr = rd_addr_q;
   assign mgmt_wr_addr = wr_addr_q;
   assign mgmt_wr_data = wr_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q          <= '0;
         grant_q        <= '0;
         cnt_q          <= '0;
         rd_addr_q      <= '0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         req_rd_valid   <= '0;
         req_rd_timeout <= '0;
         req_rd_data    <= '0;
      end else begin
         req_rd_valid   <= '0;
         req_rd_timeout <= '0;
         if (state_q == IDLE && found) begin
            grant_q <= pick;
            // read address only moves on a read grant so it stays put across writes
            if (slot_cmd[pick].wr) begin
               wr_addr_q <= slot_cmd[pick].addr;
               wr_data_q <= slot_cmd[pick].data;
            end else
               rd_addr_q <= slot_cmd[pick].addr;
         end
         if (state_q == RD_ISSUE)     cnt_q <= '0;
         else if (state_q == RD_WAIT) cnt_q <= cnt_q + 1'b1;
         if (rd_ok | rd_to) begin
            req_rd_valid[grant_q]   <= 1'b1;
            req_rd_timeout[grant_q] <= rd_to;
            req_rd_data             <= rd_ok ? mgmt_rd_data : 8'h00;
         end
         if (done)
            ptr_q <= (grant_q == PW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// Scoreboarded bench for mgmt_bus_arbiter: bus ops and read completions are
// queued at stimulus time and popped by a negedge monitor.

module tb_mgmt_bus_arbiter;
   localparam int NUM_REQ = 2;
   localparam int TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_rd_en, req_wr_en;
   logic [16*NUM_REQ-1:0] req_addr;
   logic [8*NUM_REQ-1:0]  req_wr_data;
   logic [NUM_REQ-1:0]    req_busy, req_rd_valid, req_rd_timeout, req_overflow;
   logic [7:0]            req_rd_data;
   logic                  mgmt_rd_en, mgmt_wr_en;
   logic [15:0]           mgmt_rd_addr, mgmt_wr_addr;
   logic                  mgmt_rd_valid;
   logic [7:0]            mgmt_rd_data, mgmt_wr_data;

   mgmt_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
      .req_addr(req_addr), .req_wr_data(req_wr_data),
      .req_busy(req_busy), .req_rd_valid(req_rd_valid),
      .req_rd_data(req_rd_data), .req_rd_timeout(req_rd_timeout),
      .req_overflow(req_overflow),
      .mgmt_rd_en(mgmt_rd_en), .mgmt_rd_addr(mgmt_rd_addr),
      .mgmt_rd_valid(mgmt_rd_valid), .mgmt_rd_data(mgmt_rd_data),
      .mgmt_wr_en(mgmt_wr_en), .mgmt_wr_addr(mgmt_wr_addr),
      .mgmt_wr_data(mgmt_wr_data)
   );

   always #5 clk = ~clk;

   typedef struct { bit wr; logic [15:0] addr; logic [7:0] data; } bus_t;
   typedef struct { int g; logic [7:0] data; bit to; } rsp_t;

   bus_t  exp_bus[$];
   rsp_t  exp_rsp[$];
   int    n_vec = 0, n_err = 0;
   int    rsp_delay = -1, cd = 0;
   logic [7:0]  rsp_data = 8'h00;
   bit    stray = 1'b0, rst_prev = 1'b0;
   logic [15:0] last_rd_addr = 16'h0;
   bus_t  b;
   rsp_t  r;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bus_t mk_bus(bit wr, logic [15:0] a, logic [7:0] d);
      bus_t x; x.wr = wr; x.addr = a; x.data = d; return x;
   endfunction

   function automatic rsp_t mk_rsp(int g, logic [7:0] d, bit to);
      rsp_t x; x.g = g; x.data = d; x.to = to; return x;
   endfunction

   // monitor first, then register-block model for the next cycle
   always @(negedge clk) begin
      if (rst_prev) last_rd_addr = 16'h0;
      rst_prev = rst;
      if (mgmt_wr_en | mgmt_rd_en) begin
         chk("bus_excl", 32'(mgmt_wr_en & mgmt_rd_en), 0);
         chk("bus_q_nonempty", 32'(exp_bus.size() != 0), 1);
         if (exp_bus.size() != 0) begin
            b = exp_bus.pop_front();
            chk("bus_kind", 32'(mgmt_wr_en), 32'(b.wr));
            if (b.wr) begin
               chk("wr_addr", 32'(mgmt_wr_addr), 32'(b.addr));
               chk("wr_data", 32'(mgmt_wr_data), 32'(b.data));
            end else
               chk("rd_addr", 32'(mgmt_rd_addr), 32'(b.addr));
         end
      end
      if (mgmt_rd_en) last_rd_addr = mgmt_rd_addr;
      else chk("rd_addr_hold", 32'(mgmt_rd_addr), 32'(last_rd_addr));
      if (req_rd_valid != 0 || req_rd_timeout != 0) begin
         chk("rdv_onehot", $countones(req_rd_valid), 1);
         chk("rsp_q_nonempty", 32'(exp_rsp.size() != 0), 1);
         if (exp_rsp.size() != 0) begin
            r = exp_rsp.pop_front();
            chk("rdv_who", 32'(req_rd_valid), 1 << r.g);
            chk("rd_data", 32'(req_rd_data), 32'(r.data));
            chk("rd_timeout", 32'(req_rd_timeout), r.to ? (1 << r.g) : 0);
         end
      end
      mgmt_rd_valid = 1'b0;
      if (stray) begin
         mgmt_rd_valid = 1'b1;
         mgmt_rd_data  = 8'hEE;
         stray         = 1'b0;
      end
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            mgmt_rd_valid = 1'b1;
            mgmt_rd_data  = rsp_data;
         end
      end
      if (mgmt_rd_en && rsp_delay > 0) cd = rsp_delay;
   end

   task automatic drv(input int g, input bit rd, input bit wr,
                      input logic [15:0] a, input logic [7:0] d);
      req_rd_en[g]          = rd;
      req_wr_en[g]          = wr;
      req_addr[16*g +: 16]  = a;
      req_wr_data[8*g +: 8] = d;
   endtask

   // let the strobes be sampled at the next edge, then drop them
   task automatic step();
      @(posedge clk); #1;
      req_rd_en = '0;
      req_wr_en = '0;
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (req_busy != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle_bound", 32'(n < 200), 1);
      nclk(2);
   endtask

   logic [NUM_REQ-1:0] seen;

   initial begin
      rst = 1'b1;
      req_rd_en = '0; req_wr_en = '0; req_addr = '0; req_wr_data = '0;
      mgmt_rd_valid = 1'b0; mgmt_rd_data = 8'h00;
      nclk(2);
      chk("rst_busy", 32'(req_busy), 0);
      chk("rst_rdv", 32'(req_rd_valid), 0);
      chk("rst_ovf", 32'(req_overflow), 0);
      chk("rst_en", 32'({mgmt_rd_en, mgmt_wr_en}), 0);
      chk("rst_addr", 32'({mgmt_rd_addr, mgmt_wr_addr}), 0);
      chk("rst_data", 32'({req_rd_data, mgmt_wr_data}), 0);
      rst = 1'b0;

      // single write, timing k+1..k+3
      drv(0, 0, 1, 16'h4001, 8'h0A);
      exp_bus.push_back(mk_bus(1, 16'h4001, 8'h0A));
      step();
      nclk(1);
      chk("w_busy_k1", 32'(req_busy), 2'b01);
      chk("w_en_k1", 32'(mgmt_wr_en), 0);
      nclk(1);
      chk("w_busy_k2", 32'(req_busy), 2'b01);
      chk("w_en_k2", 32'(mgmt_wr_en), 1);
      nclk(1);
      chk("w_busy_k3", 32'(req_busy), 2'b00);
      wait_idle();

      // read from requester 1, response 3 cycles after issue
      rsp_delay = 3; rsp_data = 8'h5C;
      drv(1, 1, 0, 16'h0010, 8'h00);
      exp_bus.push_back(mk_bus(0, 16'h0010, 8'h00));
      exp_rsp.push_back(mk_rsp(1, 8'h5C, 0));
      step();
      nclk(2);
      chk("r_en_k2", 32'(mgmt_rd_en), 1);
      nclk(3);
      chk("r_rdv_k5", 32'(req_rd_valid), 0);
      chk("r_busy_k5", 32'(req_busy), 2'b10);
      nclk(1);
      chk("r_rdv_k6", 32'(req_rd_valid), 2'b10);
      chk("r_busy_k6", 32'(req_busy), 2'b00);
      wait_idle();

      // simultaneous writes, twice: grant order 0,1,0,1
      for (int rep = 0; rep < 2; rep++) begin
         drv(0, 0, 1, 16'h0100 + 16'(rep), 8'h11 + 8'(rep));
         drv(1, 0, 1, 16'h0200 + 16'(rep), 8'h22 + 8'(rep));
         exp_bus.push_back(mk_bus(1, 16'h0100 + 16'(rep), 8'h11 + 8'(rep)));
         exp_bus.push_back(mk_bus(1, 16'h0200 + 16'(rep), 8'h22 + 8'(rep)));
         step();
         nclk(3);
         chk("rr_busy_k3", 32'(req_busy), 2'b10);
         nclk(1);
         chk("rr_wr1_k4", 32'({mgmt_wr_en, mgmt_wr_addr}), 32'({1'b1, 16'h0200 + 16'(rep)}));
         wait_idle();
      end

      // read timeout, then a stray response
      rsp_delay = -1;
      drv(0, 1, 0, 16'h2222, 8'h00);
      exp_bus.push_back(mk_bus(0, 16'h2222, 8'h00));
      exp_rsp.push_back(mk_rsp(0, 8'h00, 1));
      step();
      nclk(18);
      chk("to_rdv_k18", 32'(req_rd_valid), 0);
      chk("to_busy_k18", 32'(req_busy), 2'b01);
      nclk(1);
      chk("to_rdv_k19", 32'(req_rd_valid), 2'b01);
      chk("to_flag_k19", 32'(req_rd_timeout), 2'b01);
      chk("to_data_k19", 32'(req_rd_data), 0);
      stray = 1'b1;
      seen = '0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | req_rd_valid | req_rd_timeout;
      end
      chk("stray_ignored", 32'(seen), 0);
      wait_idle();

      // second strobe while busy is dropped
      drv(1, 0, 1, 16'h3000, 8'h33);
      exp_bus.push_back(mk_bus(1, 16'h3000, 8'h33));
      step();
      drv(1, 0, 1, 16'h3001, 8'h44);
      step();
      nclk(1);
      chk("ovf_busy", 32'(req_overflow), 2'b10);
      nclk(1);
      chk("ovf_clear", 32'(req_overflow), 2'b00);
      wait_idle();

      // rd+wr together: write kept, read dropped
      drv(0, 1, 1, 16'h3100, 8'h55);
      exp_bus.push_back(mk_bus(1, 16'h3100, 8'h55));
      step();
      nclk(1);
      chk("ovf_rdwr", 32'(req_overflow), 2'b01);
      chk("ovf_rdwr_busy", 32'(req_busy), 2'b01);
      wait_idle();

      // reset in RD_WAIT
      drv(1, 1, 0, 16'h0777, 8'h00);
      exp_bus.push_back(mk_bus(0, 16'h0777, 8'h00));
      step();
      nclk(3);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      nclk(1);
      chk("rstmid_busy", 32'(req_busy), 0);
      chk("rstmid_rdv", 32'(req_rd_valid), 0);
      chk("rstmid_addr", 32'(mgmt_rd_addr), 0);
      seen = '0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | req_rd_valid;
      end
      chk("rstmid_no_cpl", 32'(seen), 0);

      rsp_delay = 2; rsp_data = 8'hA7;
      drv(1, 1, 0, 16'h0042, 8'h00);
      exp_bus.push_back(mk_bus(0, 16'h0042, 8'h00));
      exp_rsp.push_back(mk_rsp(1, 8'hA7, 0));
      step();
      wait_idle();

      chk("bus_q_drained", exp_bus.size(), 0);
      chk("rsp_q_drained", exp_rsp.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
